dds_phase_calc: RTL
===================

# dds_phase_calc

Parametrised multi-lane DDS phase calculator that supersedes the single-lane fixed-width phase MAC in the DAC controller datapath. Each accepted sample produces LANES phase words, one per DAC sample in the clock. Two modes are supported:
- **absolute:** phase derived from timestamp, time offset, frequency and phase offset.
- **accumulate:** free-running phase accumulator.

Output feeds the sine LUT stage with fixed latency and no backpressure.

## Interface
- ACC_W, 48: phase accumulator / frequency tuning word width
- TIME_W, 48: timestamp and time-offset width
- PHASE_W, 14: phase-offset input width, left-aligned into ACC_W
- OUT_W, 14: output phase width per lane (top OUT_W bits of ACC_W result)
- LANES, 2: samples per clock, 1..4
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- cfg_valid  in  1  load all cfg_* registers this cycle
- cfg_mode  in  1  0 = absolute, 1 = accumulate
- cfg_freq  in  ACC_W  frequency tuning word
- cfg_time_offset  in  TIME_W  time offset (absolute mode)
- cfg_phase  in  PHASE_W  phase offset
- in_valid  in  1  sample request
- in_timestamp  in  TIME_W  timestamp of lane 0 (ignored in accumulate mode)
- out_valid  out  1  out_phase valid
- out_phase  out  LANES*OUT_W  lane k at bits [k*OUT_W +: OUT_W]

## Operation
- **Config registers:** loaded on cfg_valid.
  - Reset values: mode 0, freq 0, offset 0, phase 0.
  - A sample with in_valid in the same cycle as cfg_valid uses the OLD config.
  - Samples from the next cycle onward use the new config.
- **Phase offset alignment:** P = cfg_phase << (ACC_W-PHASE_W).
- **Absolute mode, lane k:**
  - t_k = (in_timestamp + k - cfg_time_offset) mod 2^TIME_W, unsigned.
  - r_k = (t_k * cfg_freq + P) mod 2^ACC_W.
- **Accumulate mode:**
  - Internal acc (ACC_W bits) is set to P on every cfg_valid, and on reset to 0.
  - Each in_valid cycle: r_k = (acc + k*cfg_freq) mod 2^ACC_W, then acc <= acc + LANES*cfg_freq (mod 2^ACC_W).
  - acc does not advance without in_valid.
  - If cfg_valid and in_valid coincide, the sample uses the old acc/freq and acc is then loaded with the new P; cfg_valid has priority for the acc update.
- **Output:** out_phase lane k = r_k[ACC_W-1 -: OUT_W], truncation, no rounding.
- **Arithmetic:**
  - All arithmetic is unsigned modulo; overflow wraps silently.
  - Multiplier is split into DSP-sized partial products with carries propagated across pipeline stages.
  - Result must be bit-exact to the modulo formula above.
- **Throughput:** one in_valid per cycle sustained; no gaps required; no ready signal.

## Timing
- Latency fixed at 4 cycles: in_valid at edge N -> out_valid at edge N+4 with matching data.
- out_valid is a delayed copy of in_valid. out_phase holds its last value when out_valid = 0.
- **Reset (resetn = 0 at an edge):**
  - Next-cycle outputs: out_valid = 0, out_phase = 0.
  - All pipeline valid bits, config registers and acc are cleared.
  - In-flight samples are dropped, never emitted after reset releases.
- **Reset priority:** reset overrides cfg_valid and in_valid in the same cycle.
- **Mode switch while samples are in flight:** samples already accepted complete with the config they entered with; the pipeline carries per-sample config.

## Test plan
- Absolute, LANES=2, freq=2^40, offset 0, phase 0, in_timestamp=3 -> 4 cycles later out_valid=1, lane0=192, lane1=256.
- Phase offset only: freq=0, cfg_phase=0x2000 -> both lanes 0x2000 for any timestamp.
- Wrap/negative elapsed:
  - freq=2^47, offset=5, ts=4 -> elapsed wraps to 2^48-1 -> lane0=0x2000, lane1=0 (t=0).
  - freq=2^47, offset=0, ts=2 -> lane0=0, lane1=0x2000.
- Accumulate, freq=2^40, phase 0, three back-to-back in_valid -> outputs (0,64), (128,192), (256,320) on consecutive cycles; a one-cycle in_valid gap does not advance the phase.
- cfg_valid coincident with in_valid (freq 2^40 -> 2^41), ts=1 then ts=1 next cycle -> first lane0=64, second lane0=128; exactly 4-cycle latency each.
- Reset mid-stream: 3 samples in flight, resetn low 1 cycle -> out_valid=0 for all following cycles until new in_valid, config reads back as mode 0 / freq 0 (subsequent output 0).

Source files
------------

// File: rtl/dds_phase_calc_if.sv
// rtl/dds_phase_calc_if.sv - config, sample request and phase output bundle for dds_phase_calc
interface dds_phase_calc_if #(
   parameter int ACC_W   = 48,
   parameter int TIME_W  = 48,
   parameter int PHASE_W = 14,
   parameter int OUT_W   = 14,
   parameter int LANES   = 2
);
   logic                   cfg_valid;
   logic                   cfg_mode;
   logic [ACC_W-1:0]       cfg_freq;
   logic [TIME_W-1:0]      cfg_time_offset;
   logic [PHASE_W-1:0]     cfg_phase;
   logic                   in_valid;
   logic [TIME_W-1:0]      in_timestamp;
   logic                   out_valid;
   logic [LANES*OUT_W-1:0] out_phase;

   modport master (
      output cfg_valid, cfg_mode, cfg_freq, cfg_time_offset, cfg_phase,
      output in_valid, in_timestamp,
      input  out_valid, out_phase
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_freq, cfg_time_offset, cfg_phase,
      input  in_valid, in_timestamp,
      output out_valid, out_phase
   );
endinterface

// File: rtl/dds_phase_calc.sv
// rtl/dds_phase_calc.sv - multi-lane DDS phase calculator (absolute / accumulate), fixed 4-cycle latency
// r_k = t_k * freq + addend_k, where accumulate mode uses t_k = 0 and addend_k = acc + k*freq.
module dds_phase_calc #(
   parameter int ACC_W   = 48,
   parameter int TIME_W  = 48,
   parameter int PHASE_W = 14,
   parameter int OUT_W   = 14,
   parameter int LANES   = 2
) (
   input logic             clk,
   input logic             resetn,
   dds_phase_calc_if.slave bus
);
   localparam int H  = (ACC_W + 1) / 2;
   localparam int L  = ACC_W - H;
   localparam int PW = 2 * H;
   localparam int SH = ACC_W - PHASE_W;
   localparam int SO = ACC_W - OUT_W;

   logic                   mode_q, mode_d;
   logic [ACC_W-1:0]       freq_q, freq_d;
   logic [TIME_W-1:0]      toff_q, toff_d;
   logic [PHASE_W-1:0]     phase_q, phase_d;
   logic [ACC_W-1:0]       acc_q, acc_d;
   logic [3:0]             vld_q, vld_d;
   logic                   out_valid_q, out_valid_d;
   logic [LANES*OUT_W-1:0] out_phase_q, out_phase_d;

   logic [ACC_W-1:0]       s0_t_q   [LANES];
   logic [ACC_W-1:0]       s0_t_d   [LANES];
   logic [ACC_W-1:0]       s0_add_q [LANES];
   logic [ACC_W-1:0]       s0_add_d [LANES];
   logic [ACC_W-1:0]       s0_f_q, s0_f_d;

   logic [PW-1:0]          s1_ll_q  [LANES];
   logic [PW-1:0]          s1_ll_d  [LANES];
   logic [L-1:0]           s1_x_q   [LANES];
   logic [L-1:0]           s1_x_d   [LANES];
   logic [ACC_W-1:0]       s1_add_q [LANES];
   logic [ACC_W-1:0]       s1_add_d [LANES];

   logic [H:0]             s2_lo_q  [LANES];
   logic [H:0]             s2_lo_d  [LANES];
   logic [L-1:0]           s2_hi_q  [LANES];
   logic [L-1:0]           s2_hi_d  [LANES];

   logic [OUT_W-1:0]       s3_ph_q  [LANES];
   logic [OUT_W-1:0]       s3_ph_d  [LANES];

   logic [ACC_W-1:0]       run;
   logic [ACC_W-1:0]       p_cur;
   logic [TIME_W-1:0]      t_lane;

   // Config, accumulator and stage-0 operand selection; a sample always sees the registered (old) config.
   always_comb begin
      mode_d  = mode_q;
      freq_d  = freq_q;
      toff_d  = toff_q;
      phase_d = phase_q;
      if (bus.cfg_valid) begin
         mode_d  = bus.cfg_mode;
         freq_d  = bus.cfg_freq;
         toff_d  = bus.cfg_time_offset;
         phase_d = bus.cfg_phase;
      end

      p_cur  = ACC_W'(phase_q) << SH;
      run    = acc_q;
      t_lane = '0;
      for (int k = 0; k < LANES; k++) begin
         t_lane = bus.in_timestamp + TIME_W'(k) - toff_q;
         if (mode_q) begin
            s0_t_d[k]   = '0;
            s0_add_d[k] = run;
         end else begin
            s0_t_d[k]   = ACC_W'(t_lane);
            s0_add_d[k] = p_cur;
         end
         run = run + freq_q;
      end
      s0_f_d = freq_q;

      acc_d = acc_q;
      if (bus.cfg_valid) begin
         acc_d = ACC_W'(bus.cfg_phase) << SH;
      end else if (bus.in_valid && mode_q) begin
         acc_d = run;
      end
   end

   // Stage 1: half-width partial products; the high x high term lies entirely above 2^ACC_W.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         s1_ll_d[k]  = PW'(s0_t_q[k][H-1:0]) * PW'(s0_f_q[H-1:0]);
         s1_x_d[k]   = L'(PW'(s0_t_q[k][H-1:0]) * PW'(s0_f_q[ACC_W-1:H]))
                     + L'(PW'(s0_t_q[k][ACC_W-1:H]) * PW'(s0_f_q[H-1:0]));
         s1_add_d[k] = s0_add_q[k];
      end
   end

   // Stage 2: low half sum keeps its carry; stage 3 folds that carry into the high half.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         s2_lo_d[k] = {1'b0, s1_ll_q[k][H-1:0]} + {1'b0, s1_add_q[k][H-1:0]};
         s2_hi_d[k] = s1_ll_q[k][ACC_W-1:H] + s1_x_q[k] + s1_add_q[k][ACC_W-1:H];
      end
   end

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         s3_ph_d[k] = OUT_W'({s2_hi_q[k] + L'(s2_lo_q[k][H]), s2_lo_q[k][H-1:0]} >> SO);
      end
   end

   always_comb begin
      vld_d       = {vld_q[2:0], bus.in_valid};
      out_valid_d = vld_q[3];
      out_phase_d = out_phase_q;
      if (vld_q[3]) begin
         for (int k = 0; k < LANES; k++) begin
            out_phase_d[k*OUT_W +: OUT_W] = s3_ph_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mode_q      <= 1'b0;
         freq_q      <= '0;
         toff_q      <= '0;
         phase_q     <= '0;
         acc_q       <= '0;
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         out_phase_q <= '0;
      end else begin
         mode_q      <= mode_d;
         freq_q      <= freq_d;
         toff_q      <= toff_d;
         phase_q     <= phase_d;
         acc_q       <= acc_d;
         vld_q       <= vld_d;
         out_valid_q <= out_valid_d;
         out_phase_q <= out_phase_d;
      end
   end

   // Datapath carries no reset: stale contents are never emitted because the valid chain gates the output.
   always_ff @(posedge clk) begin
      s0_t_q   <= s0_t_d;
      s0_add_q <= s0_add_d;
      s0_f_q   <= s0_f_d;
      s1_ll_q  <= s1_ll_d;
      s1_x_q   <= s1_x_d;
      s1_add_q <= s1_add_d;
      s2_lo_q  <= s2_lo_d;
      s2_hi_q  <= s2_hi_d;
      s3_ph_q  <= s3_ph_d;
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_phase = out_phase_q;
endmodule
